// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver.
// Holds the FSM state encoding, the error-vector bit positions and the data-width codes.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BRKWT
   } rx_state_t;

   localparam int ERR_PAR = 0;
   localparam int ERR_FRM = 1;
   localparam int ERR_BRK = 2;

   localparam logic [1:0] DBITS_5 = 2'd0;
   localparam logic [1:0] DBITS_6 = 2'd1;
   localparam logic [1:0] DBITS_7 = 2'd2;
   localparam logic [1:0] DBITS_8 = 2'd3;

   function automatic logic [3:0] dataBitCount(input logic [1:0] code);
      case (code)
         DBITS_5: return 4'd5;
         DBITS_6: return 4'd6;
         DBITS_7: return 4'd7;
         DBITS_8: return 4'd8;
         default: return 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO: push/full on the write side, valid/ready on the read side.
// Full is judged before any same-cycle pop, so a pop never makes room for a push.
module uart_rx_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_full,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [AW:0]      r_count;

   logic w_full;
   logic w_empty;
   logic w_doPush;
   logic w_doPop;

   assign w_full   = (r_count == (AW+1)'(DEPTH));
   assign w_empty  = (r_count == '0);
   assign w_doPush = i_push && !w_full;
   assign w_doPop  = i_ready && !w_empty;

   assign o_full  = w_full;
   assign o_valid = !w_empty;
   assign o_data  = r_mem[r_rdPtr];

   // Storage is cleared on reset so the read port shows zero while empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
            r_wrPtr        <= r_wrPtr + 1'b1;
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver: runtime divisor, 5-8 data bits, optional parity, 1/2 stop bits.
// Each bit is decided by a 3-sample majority vote; frames leave through a small FIFO.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter int DIV_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic [1:0]       cfg_data_bits,
   input  logic             cfg_parity_en,
   input  logic             cfg_parity_odd,
   input  logic             cfg_stop2,
   input  logic             rx_i,
   output logic [7:0]       m_data_o,
   output logic [2:0]       m_err_o,
   output logic             m_valid_o,
   input  logic             m_ready_i,
   output logic             overrun_o,
   output logic             busy_o
);

   localparam int OS_W = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0] T_SAMPLE_A = OS_W'(OVERSAMPLE/2 - 1);
   localparam logic [OS_W-1:0] T_SAMPLE_B = OS_W'(OVERSAMPLE/2);
   localparam logic [OS_W-1:0] T_VOTE     = OS_W'(OVERSAMPLE/2 + 1);
   localparam logic [OS_W-1:0] T_END      = OS_W'(OVERSAMPLE - 1);

   rx_state_t r_state;
   rx_state_t w_next;

   logic r_sync1;
   logic r_sync2;
   logic r_rxd;

   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_divCnt;
   logic [OS_W-1:0]  r_osCnt;
   logic             r_s0;
   logic             r_s1;

   logic [3:0] r_nBits;
   logic       r_parEn;
   logic       r_parOdd;
   logic       r_stop2;

   logic [3:0] r_bitCnt;
   logic       r_stopCnt;
   logic [7:0] r_data;
   logic       r_parBit;
   logic       r_perr;
   logic       r_ferr;

   logic             w_fall;
   logic             w_tick;
   logic             w_sampleA;
   logic             w_sampleB;
   logic             w_vote;
   logic             w_bitEnd;
   logic             w_voteVal;
   logic [DIV_W-1:0] w_divEff;
   logic             w_commit;
   logic             w_ferrFinal;
   logic             w_brk;
   logic [2:0]       w_err;
   logic             w_fifoFull;
   logic [10:0]      w_fifoOut;

   assign w_fall    = r_rxd && !r_sync2;
   assign w_divEff  = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
   assign w_tick    = (r_state != ST_IDLE) && (r_divCnt == r_div);
   assign w_sampleA = w_tick && (r_osCnt == T_SAMPLE_A);
   assign w_sampleB = w_tick && (r_osCnt == T_SAMPLE_B);
   assign w_vote    = w_tick && (r_osCnt == T_VOTE);
   assign w_bitEnd  = w_tick && (r_osCnt == T_END);
   assign w_voteVal = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Bit-level transitions happen at the end of a bit; only the false-start
   // check and the final stop-bit commit act at the mid-bit vote.
   always_comb begin
      w_next      = r_state;
      w_commit    = 1'b0;
      w_ferrFinal = r_ferr;
      case (r_state)
         ST_IDLE: begin
            if (w_fall) w_next = ST_START;
         end
         ST_START: begin
            if (w_vote && w_voteVal)  w_next = ST_IDLE;
            else if (w_bitEnd)        w_next = ST_DATA;
         end
         ST_DATA: begin
            if (w_bitEnd && (r_bitCnt == r_nBits)) begin
               w_next = r_parEn ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (w_bitEnd) w_next = ST_STOP;
         end
         ST_STOP: begin
            if (w_vote) begin
               w_ferrFinal = r_ferr | ~w_voteVal;
               if (r_stopCnt == r_stop2) begin
                  w_commit = 1'b1;
                  w_next   = w_ferrFinal ? ST_BRKWT : ST_IDLE;
               end
            end
         end
         ST_BRKWT: begin
            if (r_sync2) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Synchroniser, tick generation and frame datapath; config is captured at start detect.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_rxd     <= 1'b1;
         r_div     <= '0;
         r_divCnt  <= '0;
         r_osCnt   <= '0;
         r_s0      <= 1'b1;
         r_s1      <= 1'b1;
         r_nBits   <= 4'd8;
         r_parEn   <= 1'b0;
         r_parOdd  <= 1'b0;
         r_stop2   <= 1'b0;
         r_bitCnt  <= '0;
         r_stopCnt <= 1'b0;
         r_data    <= '0;
         r_parBit  <= 1'b0;
         r_perr    <= 1'b0;
         r_ferr    <= 1'b0;
      end else begin
         r_sync1 <= rx_i;
         r_sync2 <= r_sync1;
         r_rxd   <= r_sync2;
         if (r_state == ST_IDLE) begin
            r_divCnt <= '0;
            r_osCnt  <= '0;
            if (w_fall) begin
               r_div     <= w_divEff;
               r_nBits   <= dataBitCount(cfg_data_bits);
               r_parEn   <= cfg_parity_en;
               r_parOdd  <= cfg_parity_odd;
               r_stop2   <= cfg_stop2;
               r_bitCnt  <= '0;
               r_stopCnt <= 1'b0;
               r_data    <= '0;
               r_parBit  <= 1'b0;
               r_perr    <= 1'b0;
               r_ferr    <= 1'b0;
            end
         end else begin
            r_divCnt <= (r_divCnt == r_div) ? '0 : r_divCnt + 1'b1;
            if (w_tick) begin
               r_osCnt <= (r_osCnt == T_END) ? '0 : r_osCnt + 1'b1;
            end
            if (w_sampleA) r_s0 <= r_sync2;
            if (w_sampleB) r_s1 <= r_sync2;
            if (w_vote) begin
               case (r_state)
                  ST_DATA: begin
                     r_data[r_bitCnt[2:0]] <= w_voteVal;
                     r_bitCnt              <= r_bitCnt + 1'b1;
                  end
                  ST_PARITY: begin
                     r_parBit <= w_voteVal;
                     r_perr   <= ((^r_data) ^ w_voteVal) != r_parOdd;
                  end
                  ST_STOP: begin
                     r_ferr <= w_ferrFinal;
                  end
                  default: ;
               endcase
            end
            if (w_bitEnd && (r_state == ST_STOP)) begin
               r_stopCnt <= 1'b1;
            end
         end
      end
   end

   assign w_brk = w_ferrFinal && (r_data == 8'h00) && (!r_parEn || !r_parBit);

   always_comb begin
      w_err          = 3'b000;
      w_err[ERR_BRK] = w_brk;
      w_err[ERR_FRM] = w_ferrFinal;
      w_err[ERR_PAR] = r_perr;
   end

   uart_rx_fifo #(
      .WIDTH (11),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_commit),
      .i_data  ({w_err, r_data}),
      .o_full  (w_fifoFull),
      .o_valid (m_valid_o),
      .i_ready (m_ready_i),
      .o_data  (w_fifoOut)
   );

   assign m_data_o  = w_fifoOut[7:0];
   assign m_err_o   = w_fifoOut[10:8];
   assign overrun_o = w_commit && w_fifoFull && !rst;
   assign busy_o    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: framing formats, parity, glitch rejection, break,
// overrun and mid-frame reset, with popped characters collected by a small monitor.
module tb_uart_rx_core;

   localparam int DIV26   = 26;
   localparam int BIT26   = (DIV26 + 1) * 16;
   localparam int DIV325  = 325;
   localparam int BIT325  = (DIV325 + 1) * 16;

   logic        clk;
   logic        rst;
   logic [15:0] cfg_div;
   logic [1:0]  cfg_data_bits;
   logic        cfg_parity_en;
   logic        cfg_parity_odd;
   logic        cfg_stop2;
   logic        rx_i;
   logic [7:0]  m_data_o;
   logic [2:0]  m_err_o;
   logic        m_valid_o;
   logic        m_ready_i;
   logic        overrun_o;
   logic        busy_o;

   int errors = 0;
   int checks = 0;
   int ovCount = 0;
   logic [10:0] rxQ [$];

   uart_rx_core dut (
      .clk            (clk),
      .rst            (rst),
      .cfg_div        (cfg_div),
      .cfg_data_bits  (cfg_data_bits),
      .cfg_parity_en  (cfg_parity_en),
      .cfg_parity_odd (cfg_parity_odd),
      .cfg_stop2      (cfg_stop2),
      .rx_i           (rx_i),
      .m_data_o       (m_data_o),
      .m_err_o        (m_err_o),
      .m_valid_o      (m_valid_o),
      .m_ready_i      (m_ready_i),
      .overrun_o      (overrun_o),
      .busy_o         (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every accepted pop as {err, data} and count overrun pulses.
   always @(negedge clk) begin
      if (m_valid_o && m_ready_i) rxQ.push_back({m_err_o, m_data_o});
      if (overrun_o) ovCount++;
   end

   task automatic sendFrame(input logic [7:0] data, input int nBits, input logic parEn,
                            input logic parBit, input int nStop, input int bitClk);
      rx_i = 1'b0;
      repeat (bitClk) @(negedge clk);
      for (int i = 0; i < nBits; i++) begin
         rx_i = data[i];
         repeat (bitClk) @(negedge clk);
      end
      if (parEn) begin
         rx_i = parBit;
         repeat (bitClk) @(negedge clk);
      end
      for (int i = 0; i < nStop; i++) begin
         rx_i = 1'b1;
         repeat (bitClk) @(negedge clk);
      end
      rx_i = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy_o); end
      checks++; if (m_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", m_valid_o); end
      checks++; if (m_data_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got=%h exp=00", m_data_o); end
      checks++; if (m_err_o !== 3'b000) begin errors++; $display("[TB] FAIL reset_err got=%b exp=000", m_err_o); end
      checks++; if (overrun_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun got=%b exp=0", overrun_o); end
   endtask

   task automatic test_8n1();
      logic [10:0] got;
      cfg_data_bits = 2'd3; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
      rxQ.delete();
      sendFrame(8'hA5, 8, 1'b0, 1'b0, 1, BIT26);
      checks++; if (rxQ.size() != 1) begin errors++; $display("[TB] FAIL 8n1_count got=%0d exp=1", rxQ.size()); end
      got = 11'h7FF;
      if (rxQ.size() > 0) got = rxQ.pop_front();
      checks++; if (got[7:0] !== 8'hA5) begin errors++; $display("[TB] FAIL 8n1_data got=%h exp=a5", got[7:0]); end
      checks++; if (got[10:8] !== 3'b000) begin errors++; $display("[TB] FAIL 8n1_err got=%b exp=000", got[10:8]); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL 8n1_idle got=%b exp=0", busy_o); end
   endtask

   task automatic test_parity();
      logic [10:0] got;
      // 0x41 has two ones in 7 bits: even parity bit 0, odd parity bit would be 1.
      cfg_data_bits = 2'd2; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b1;
      rxQ.delete();
      sendFrame(8'h41, 7, 1'b1, 1'b0, 2, BIT26);
      checks++; if (rxQ.size() != 1) begin errors++; $display("[TB] FAIL 7e2_count got=%0d exp=1", rxQ.size()); end
      got = 11'h7FF;
      if (rxQ.size() > 0) got = rxQ.pop_front();
      checks++; if (got !== {3'b000, 8'h41}) begin errors++; $display("[TB] FAIL 7e2_entry got=%h exp=%h", got, {3'b000, 8'h41}); end
      cfg_parity_odd = 1'b1; cfg_stop2 = 1'b0;
      sendFrame(8'h41, 7, 1'b1, 1'b0, 1, BIT26);
      checks++; if (rxQ.size() != 1) begin errors++; $display("[TB] FAIL 7o1_count got=%0d exp=1", rxQ.size()); end
      got = 11'h7FF;
      if (rxQ.size() > 0) got = rxQ.pop_front();
      checks++; if (got[7:0] !== 8'h41) begin errors++; $display("[TB] FAIL 7o1_data got=%h exp=41", got[7:0]); end
      checks++; if (got[10:8] !== 3'b001) begin errors++; $display("[TB] FAIL 7o1_perr got=%b exp=001", got[10:8]); end
   endtask

   task automatic test_glitch();
      cfg_data_bits = 2'd3; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
      rxQ.delete();
      rx_i = 1'b0;
      repeat (3 * (DIV26 + 1)) @(negedge clk);
      rx_i = 1'b1;
      repeat (DIV26 + 1) @(negedge clk);
      checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL glitch_detect got=%b exp=1", busy_o); end
      repeat (BIT26 - 4 * (DIV26 + 1)) @(negedge clk);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy got=%b exp=0", busy_o); end
      checks++; if (rxQ.size() != 0) begin errors++; $display("[TB] FAIL glitch_output got=%0d exp=0", rxQ.size()); end
   endtask

   task automatic test_break();
      logic [10:0] got;
      rxQ.delete();
      rx_i = 1'b0;
      repeat (20 * BIT26) @(negedge clk);
      checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL break_hold got=%b exp=1", busy_o); end
      rx_i = 1'b1;
      repeat (20) @(negedge clk);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL break_release got=%b exp=0", busy_o); end
      checks++; if (rxQ.size() != 1) begin errors++; $display("[TB] FAIL break_count got=%0d exp=1", rxQ.size()); end
      got = 11'h7FF;
      if (rxQ.size() > 0) got = rxQ.pop_front();
      checks++; if (got !== {3'b110, 8'h00}) begin errors++; $display("[TB] FAIL break_entry got=%h exp=%h", got, {3'b110, 8'h00}); end
      repeat (BIT26) @(negedge clk);
      sendFrame(8'h55, 8, 1'b0, 1'b0, 1, BIT26);
      checks++; if (rxQ.size() != 1) begin errors++; $display("[TB] FAIL after_break_count got=%0d exp=1", rxQ.size()); end
      got = 11'h7FF;
      if (rxQ.size() > 0) got = rxQ.pop_front();
      checks++; if (got !== {3'b000, 8'h55}) begin errors++; $display("[TB] FAIL after_break_entry got=%h exp=%h", got, {3'b000, 8'h55}); end
   endtask

   task automatic test_overrun();
      int ovBase;
      logic [10:0] got;
      rxQ.delete();
      ovBase = ovCount;
      m_ready_i = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         sendFrame(8'(c), 8, 1'b0, 1'b0, 1, BIT26);
      end
      checks++; if (ovCount - ovBase != 1) begin errors++; $display("[TB] FAIL overrun_pulses got=%0d exp=1", ovCount - ovBase); end
      checks++; if (m_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL overrun_valid got=%b exp=1", m_valid_o); end
      m_ready_i = 1'b1;
      repeat (10) @(negedge clk);
      checks++; if (rxQ.size() != 4) begin errors++; $display("[TB] FAIL overrun_count got=%0d exp=4", rxQ.size()); end
      for (int c = 1; c <= 4; c++) begin
         got = 11'h7FF;
         if (rxQ.size() > 0) got = rxQ.pop_front();
         checks++; if (got !== {3'b000, 8'(c)}) begin errors++; $display("[TB] FAIL overrun_order%0d got=%h exp=%h", c, got, {3'b000, 8'(c)}); end
      end
      checks++; if (m_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL overrun_drained got=%b exp=0", m_valid_o); end
   endtask

   task automatic test_reset_mid();
      int ovBase;
      logic [10:0] got;
      logic [7:0]  pat;
      rxQ.delete();
      ovBase = ovCount;
      pat = 8'h3C;
      rx_i = 1'b0;
      repeat (BIT26) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx_i = pat[i];
         repeat (BIT26) @(negedge clk);
      end
      rx_i = pat[3];
      repeat (BIT26 / 2) @(negedge clk);
      checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_busy_before got=%b exp=1", busy_o); end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rx_i = 1'b1;
      @(negedge clk);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got=%b exp=0", busy_o); end
      checks++; if (m_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid got=%b exp=0", m_valid_o); end
      checks++; if ({m_err_o, m_data_o} !== 11'h000) begin errors++; $display("[TB] FAIL rstmid_outputs got=%h exp=000", {m_err_o, m_data_o}); end
      repeat (BIT26) @(negedge clk);
      checks++; if (rxQ.size() != 0 || ovCount != ovBase) begin errors++; $display("[TB] FAIL rstmid_nooutput got=%0d/%0d exp=0/0", rxQ.size(), ovCount - ovBase); end
      sendFrame(8'h3C, 8, 1'b0, 1'b0, 1, BIT26);
      checks++; if (rxQ.size() != 1) begin errors++; $display("[TB] FAIL rstmid_next_count got=%0d exp=1", rxQ.size()); end
      got = 11'h7FF;
      if (rxQ.size() > 0) got = rxQ.pop_front();
      checks++; if (got !== {3'b000, 8'h3C}) begin errors++; $display("[TB] FAIL rstmid_next_entry got=%h exp=%h", got, {3'b000, 8'h3C}); end
   endtask

   task automatic test_5n1_9600();
      logic [10:0] got;
      rxQ.delete();
      cfg_div = 16'(DIV325);
      cfg_data_bits = 2'd0; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
      sendFrame(8'h1F, 5, 1'b0, 1'b0, 1, BIT325);
      checks++; if (rxQ.size() != 1) begin errors++; $display("[TB] FAIL 5n1_count got=%0d exp=1", rxQ.size()); end
      got = 11'h7FF;
      if (rxQ.size() > 0) got = rxQ.pop_front();
      checks++; if (got !== {3'b000, 8'h1F}) begin errors++; $display("[TB] FAIL 5n1_entry got=%h exp=%h", got, {3'b000, 8'h1F}); end
   endtask

   initial begin
      rst            = 1'b1;
      rx_i           = 1'b1;
      m_ready_i      = 1'b1;
      cfg_div        = 16'(DIV26);
      cfg_data_bits  = 2'd3;
      cfg_parity_en  = 1'b0;
      cfg_parity_odd = 1'b0;
      cfg_stop2      = 1'b0;
      test_reset();
      test_8n1();
      test_parity();
      test_glitch();
      test_break();
      test_overrun();
      test_reset_mid();
      test_5n1_9600();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
